// File: rtl/sec_display_if.sv
// Bus between the seconds counter and the seven-segment scan driver.
// master: seconds-counter side, drives secs and observes the display.
// slave:  the sec_display block.
interface sec_display_if;
  logic [16:0] secs;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        busy;

  modport master (output secs, input an, seg, dp, busy);
  modport slave  (input secs, output an, seg, dp, busy);
endinterface

// File: rtl/sec_display.sv
// sec_display: converts a 17-bit binary seconds value to six BCD digits with
// a shift-and-add-3 FSM and time-multiplexes them onto an 8-digit
// seven-segment display (active-low anodes and segments).
// Optional feature macro: SEC_DISPLAY_BLANK_EN -- blank leading zero digits
// above the most significant nonzero digit (digit 0 always shown).
module sec_display #(
  parameter int unsigned SCAN_DIV = 100000
) (
  input  logic         clk,
  input  logic         reset,
  sec_display_if.slave bus
);

  localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_t;

  state_t        r_state;
  logic [16:0]   r_bin;
  logic [16:0]   r_last;
  logic [23:0]   r_bcd;
  logic [23:0]   r_disp;
  logic [4:0]    r_bitcnt;
  logic          r_busy;

  logic [PW-1:0] r_pre;
  logic [2:0]    r_idx;
  logic [7:0]    r_an;
  logic [6:0]    r_seg;

  logic [23:0]   w_bcd_adj;
  logic          w_wrap;
  logic [2:0]    w_idx_nxt;
  logic [3:0]    w_nib;
  logic          w_blank;
  logic [7:0]    w_an_nxt;
  logic [6:0]    w_seg_nxt;

  // Add-3 correction on every BCD nibble that is 5 or more before the shift
  always_comb begin
    w_bcd_adj = r_bcd;
    for (int unsigned i = 0; i < 6; i++) begin
      if (r_bcd[i*4 +: 4] >= 4'd5)
        w_bcd_adj[i*4 +: 4] = r_bcd[i*4 +: 4] + 4'd3;
    end
  end

  // Conversion FSM: capture on change, 17 shift steps, then one-cycle load
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_busy   <= 1'b0;
      r_last   <= '0;
      r_bin    <= '0;
      r_bcd    <= '0;
      r_bitcnt <= '0;
      r_disp   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.secs != r_last) begin
            r_bin    <= bus.secs;
            r_last   <= bus.secs;
            r_bcd    <= '0;
            r_bitcnt <= '0;
            r_busy   <= 1'b1;
            r_state  <= SHIFT;
          end
        end
        SHIFT: begin
          r_bcd    <= {w_bcd_adj[22:0], r_bin[16]};
          r_bin    <= {r_bin[15:0], 1'b0};
          r_bitcnt <= r_bitcnt + 5'd1;
          if (r_bitcnt == 5'd16)
            r_state <= LOAD;
        end
        LOAD: begin
          // all six digits move together so a scan slot never sees a mix
          r_disp  <= r_bcd;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Next digit index, selected nibble and leading-zero blanking
  always_comb begin
    w_wrap    = (r_pre == PW'(SCAN_DIV - 1));
    w_idx_nxt = r_idx;
    if (w_wrap)
      w_idx_nxt = (r_idx == 3'd5) ? 3'd0 : r_idx + 3'd1;
    case (w_idx_nxt)
      3'd0:    w_nib = r_disp[3:0];
      3'd1:    w_nib = r_disp[7:4];
      3'd2:    w_nib = r_disp[11:8];
      3'd3:    w_nib = r_disp[15:12];
      3'd4:    w_nib = r_disp[19:16];
      3'd5:    w_nib = r_disp[23:20];
      default: w_nib = 4'hF;
    endcase
`ifdef SEC_DISPLAY_BLANK_EN
    w_blank = (w_idx_nxt != 3'd0) && ((r_disp >> {w_idx_nxt, 2'b00}) == 24'd0);
`else
    w_blank = 1'b0;
`endif
  end

  // Anode and segment decode for the slot that becomes active on this edge
  always_comb begin
    w_an_nxt = w_blank ? 8'hFF : ~(8'd1 << w_idx_nxt);
    case (w_nib)
      4'd0:    w_seg_nxt = 7'b1000000;
      4'd1:    w_seg_nxt = 7'b1111001;
      4'd2:    w_seg_nxt = 7'b0100100;
      4'd3:    w_seg_nxt = 7'b0110000;
      4'd4:    w_seg_nxt = 7'b0011001;
      4'd5:    w_seg_nxt = 7'b0010010;
      4'd6:    w_seg_nxt = 7'b0000010;
      4'd7:    w_seg_nxt = 7'b1111000;
      4'd8:    w_seg_nxt = 7'b0000000;
      4'd9:    w_seg_nxt = 7'b0010000;
      default: w_seg_nxt = 7'b1111111;
    endcase
    if (w_blank)
      w_seg_nxt = 7'b1111111;
  end

  // Scan prescaler, digit index and registered an/seg; an/seg are decoded
  // from the next index so they switch on the same edge as the index
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pre <= '0;
      r_idx <= '0;
      r_an  <= 8'hFF;
      r_seg <= 7'h7F;
    end else begin
      r_pre <= w_wrap ? '0 : r_pre + PW'(1);
      r_idx <= w_idx_nxt;
      r_an  <= w_an_nxt;
      r_seg <= w_seg_nxt;
    end
  end

  assign bus.an   = r_an;
  assign bus.seg  = r_seg;
  assign bus.dp   = 1'b1;
  assign bus.busy = r_busy;

endmodule

// File: tb/tb_sec_display.sv
// Self-checking bench for sec_display (SCAN_DIV = 4).
module tb_sec_display;

  localparam int SD = 4;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_bad;
  int   cyc;

  sec_display_if u_if ();

  sec_display #(.SCAN_DIV(SD)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Clock edges since reset release; the active slot follows from this count
  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  typedef struct {
    int          secs;
    logic [23:0] bcd;
  } vec_t;

  vec_t tbl[10];

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [23:0] to_bcd(input int v);
    logic [23:0] r;
    int p;
    r = '0;
    p = 1;
    for (int i = 0; i < 6; i++) begin
      r = r | (24'((v / p) % 10) << (4 * i));
      p = p * 10;
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One negedge sample of an/seg against the expected digits
  task automatic check_cycle(input logic [23:0] bcd, input string tag);
    int          slot;
    logic [3:0]  nib;
    logic        blank;
    logic [7:0]  e_an;
    logic [6:0]  e_seg;
    @(negedge clk);
    slot  = (cyc / SD) % 6;
    nib   = 4'((bcd >> (slot * 4)) & 24'hF);
    blank = 1'b0;
`ifdef SEC_DISPLAY_BLANK_EN
    if (slot != 0 && (bcd >> (slot * 4)) == 24'd0) blank = 1'b1;
`endif
    e_an  = blank ? 8'hFF : ~(8'h01 << slot);
    e_seg = blank ? 7'h7F : seg_of(nib);
    chk({tag, "_an"},  32'(u_if.an),  32'(e_an));
    chk({tag, "_seg"}, 32'(u_if.seg), 32'(e_seg));
  endtask

  task automatic check_round(input logic [23:0] bcd, input string tag);
    for (int k = 0; k < 6 * SD; k++) check_cycle(bcd, tag);
    chk({tag, "_dp"}, 32'(u_if.dp), 32'd1);
  endtask

  // Wait until busy has been low for three consecutive samples (bounded)
  task automatic wait_idle(input string tag);
    int low;
    int n;
    low = 0;
    n   = 0;
    while (low < 3 && n < 300) begin
      @(negedge clk);
      n++;
      if (u_if.busy) low = 0;
      else           low++;
    end
    chk({tag, "_settle"}, 32'(low >= 3), 32'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    int gap;
    int v;
    int v2;

    n_cmp = 0;
    n_bad = 0;
    tbl[0] = '{0,      24'h000000};
    tbl[1] = '{59,     24'h000059};
    tbl[2] = '{131071, 24'h131071};
    tbl[3] = '{9,      24'h000009};
    tbl[4] = '{10,     24'h000010};
    tbl[5] = '{99999,  24'h099999};
    tbl[6] = '{100000, 24'h100000};
    tbl[7] = '{86399,  24'h086399};
    tbl[8] = '{1,      24'h000001};
    tbl[9] = '{70,     24'h000070};

    // Reset state
    reset     = 1'b1;
    u_if.secs = 17'd0;
    repeat (3) @(negedge clk);
    chk("rst_an",   32'(u_if.an),   32'hFF);
    chk("rst_seg",  32'(u_if.seg),  32'h7F);
    chk("rst_dp",   32'(u_if.dp),   32'd1);
    chk("rst_busy", 32'(u_if.busy), 32'd0);
    reset = 1'b0;

    // Idle scan of value 0 straight after release, no conversion
    check_round(24'h000000, "scan0");
    chk("scan0_busy", 32'(u_if.busy), 32'd0);

    // 0 -> 59: busy for 18 cycles, then shown
    u_if.secs = 17'd59;
    @(negedge clk);
    cnt = 0;
    while (u_if.busy && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
    chk("busy_len59", cnt, 18);
    wait_idle("v59");
    check_round(24'h000059, "v59");

    // Table of values and expected digit strings
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      u_if.secs = 17'(tbl[i].secs);
      wait_idle($sformatf("tbl%0d", i));
      check_round(tbl[i].bcd, $sformatf("tbl%0d", i));
    end

    // 10 -> 11 during SHIFT cycle 5: first conversion finishes, second follows
    @(negedge clk);
    u_if.secs = 17'd10;
    repeat (5) @(negedge clk);
    u_if.secs = 17'd11;
    cnt = 0;
    while (u_if.busy && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
    gap = 0;
    while (!u_if.busy && gap < 50) begin
      gap++;
      @(negedge clk);
    end
    chk("chg_gap", gap, 1);
    wait_idle("chg");
    check_round(24'h000011, "chg");

    // Reset on SHIFT cycle 8 of 1234
    @(negedge clk);
    u_if.secs = 17'd1234;
    repeat (8) @(negedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("mrst_busy", 32'(u_if.busy), 32'd0);
    chk("mrst_an",   32'(u_if.an),   32'hFF);
    chk("mrst_seg",  32'(u_if.seg),  32'h7F);
    @(negedge clk);
    reset = 1'b0;
    check_cycle(24'h000000, "mrst_clr");
    chk("mrst_restart", 32'(u_if.busy), 32'd1);
    for (int k = 0; k < 7; k++) check_cycle(24'h000000, "mrst_clr");
    wait_idle("mrst");
    check_round(24'h001234, "mrst");

    // Random values, some changed again mid-conversion
    for (int it = 0; it < 20; it++) begin
      v = int'($urandom_range(131071, 0));
      @(negedge clk);
      u_if.secs = 17'(v);
      if ($urandom_range(1, 0) == 1) begin
        repeat ($urandom_range(20, 1)) @(negedge clk);
        v2 = int'($urandom_range(131071, 0));
        u_if.secs = 17'(v2);
        v = v2;
      end
      wait_idle($sformatf("rnd%0d", it));
      check_round(to_bcd(v), $sformatf("rnd%0d", it));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
